seven_segment_display: RTL and testbench
========================================

SEVEN_SEGMENT_DISPLAY -- requirements
Module: seven_segment_display

Interface
REQ-001 Parameter HEX_EN, default 1, meaning: 1 = codes 10-15 decode to A,b,C,d,E,F; 0 = codes 10-15 blank all segments (BCD-only).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in  input  4  hex/BCD digit to display.
REQ-005 dp  input  1  decimal-point request, 1 = lit.
REQ-006 blank  input  1  1 = all segments and dp dark.
REQ-007 lamp_test  input  1  1 = all segments and dp lit.
REQ-008 segment  output  8  registered pattern: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp; active-high (1 = lit) unless REQ-021 applies.

Function
REQ-009 segment SHALL be driven only from a register; no combinational path from any input to segment.
REQ-010 Latency SHALL be exactly one clock: the value sampled on rising edge N appears on segment after edge N and holds until edge N+1.
REQ-011 Decode (lit pattern, bits 6..0 as hex) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-012 With HEX_EN=0, inputs 10-15 SHALL produce bits 6..0 = 00 (dark); inputs 0-9 unchanged.
REQ-013 segment[7] SHALL equal dp during normal decode.
REQ-014 Priority SHALL be lamp_test > blank > decode; lamp_test=1 gives lit pattern FF regardless of in, dp and blank.
REQ-015 blank=1 with lamp_test=0 gives lit pattern 00, including dp.
REQ-016 Simultaneous changes of in, dp, blank and lamp_test on the same edge SHALL resolve per REQ-014 using the values sampled on that edge only.
REQ-017 The decoder SHALL be a complete case over all 16 codes with no latches; X on in is not required to be handled.

Reset
REQ-018 rst_n=0 SHALL immediately, without a clock edge, force segment to the dark pattern (lit pattern 00).
REQ-019 While rst_n=0, segment SHALL hold the dark pattern regardless of clk and inputs.
REQ-020 After rst_n deasserts, the first rising clk edge SHALL load the decode of the then-current inputs; reset deassertion alone SHALL not change segment.

Configuration
REQ-021 Macro SEG_COMMON_ANODE_EN: when defined, every segment bit, dp included, SHALL be inverted at the register input (0 = lit), so reset/dark = FF and lamp test = 00; when undefined, polarity is active-high per REQ-008. Decode, priority and timing are identical in both builds.

Verification
REQ-022 Reset: rst_n=0 mid-clock with in=8 previously displayed -> segment=00 immediately (FF with SEG_COMMON_ANODE_EN); holds until first edge after release.
REQ-023 Even-code sweep: in = 0,2,4,...,14, dp=0, one code per 10 time units -> segment one clock later = 3F, 5B, 66, 7D, 7F, 77, 39, 79.
REQ-024 Full sweep: in = 0..15 with HEX_EN=0 -> 0..9 match REQ-011, 10..15 give 00.
REQ-025 Decimal point: in=5, dp=1 -> segment=ED; dp=0 next edge -> segment=6D.
REQ-026 Priority: in=3, dp=1, blank=1, lamp_test=1 -> FF; drop lamp_test -> 00; drop blank -> CF.
REQ-027 Polarity build with SEG_COMMON_ANODE_EN: in=1, dp=0 -> segment=F9; lamp_test=1 -> 00.

Source files
------------

// File: rtl/seven_segment_display.sv
// seven_segment_display: registered 7-segment decoder with dp, blank and lamp test.
// Define SEG_COMMON_ANODE_EN for active-low (common-anode) segment polarity.
module seven_segment_display #(
  parameter int HEX_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  input  logic       dp,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [7:0] segment
);
`ifdef SEG_COMMON_ANODE_EN
  localparam logic [7:0] pol = 8'hFF;
`else
  localparam logic [7:0] pol = 8'h00;
`endif
  logic [6:0] glyph;
  logic [7:0] lit;
  always_comb begin
    glyph = 7'h00;
    case (in)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = HEX_EN != 0 ? 7'h77 : 7'h00;
      4'hB: glyph = HEX_EN != 0 ? 7'h7C : 7'h00;
      4'hC: glyph = HEX_EN != 0 ? 7'h39 : 7'h00;
      4'hD: glyph = HEX_EN != 0 ? 7'h5E : 7'h00;
      4'hE: glyph = HEX_EN != 0 ? 7'h79 : 7'h00;
      4'hF: glyph = HEX_EN != 0 ? 7'h71 : 7'h00;
    endcase
  end
  assign lit = lamp_test ? 8'hFF : blank ? 8'h00 : {dp, glyph};
  // polarity applied before the register so the output stays a pure flop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) segment <= pol;
    else segment <= lit ^ pol;
endmodule

// File: tb/tb_seven_segment_display.sv
// tb_seven_segment_display: directed and random checks of hex and BCD-only decoders against a table model.
module tb_seven_segment_display;
`ifdef SEG_COMMON_ANODE_EN
  localparam logic [7:0] pol = 8'hFF;
`else
  localparam logic [7:0] pol = 8'h00;
`endif
  localparam logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [7:0] even_exp [8] = '{8'h3F, 8'h5B, 8'h66, 8'h7D, 8'h7F, 8'h77, 8'h39, 8'h79};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] in = 4'h0;
  logic dp = 1'b0, blank = 1'b0, lamp_test = 1'b0;
  logic [7:0] seg_hex, seg_bcd, prev_hex, prev_bcd;
  int n_checks = 0;
  int n_fails = 0;
  seven_segment_display #(.HEX_EN(1)) u_hex (.clk(clk), .rst_n(rst_n), .in(in), .dp(dp),
    .blank(blank), .lamp_test(lamp_test), .segment(seg_hex));
  seven_segment_display #(.HEX_EN(0)) u_bcd (.clk(clk), .rst_n(rst_n), .in(in), .dp(dp),
    .blank(blank), .lamp_test(lamp_test), .segment(seg_bcd));
  always #5 clk = ~clk;
  function automatic logic [7:0] model(input bit hex, input logic [3:0] i, input logic d, b, l);
    logic [7:0] lit;
    if (l) lit = 8'hFF;
    else if (b) lit = 8'h00;
    else lit = {d, (hex || i < 4'd10) ? tbl[i] : 7'h00};
    return lit ^ pol;
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] i, input logic d, b, l);
    @(negedge clk);
    in = i; dp = d; blank = b; lamp_test = l;
    #1;
    chk("hold_hex", seg_hex, prev_hex);
    chk("hold_bcd", seg_bcd, prev_bcd);
    @(posedge clk);
    #1;
    prev_hex = model(1'b1, i, d, b, l);
    prev_bcd = model(1'b0, i, d, b, l);
    chk("dec_hex", seg_hex, prev_hex);
    chk("dec_bcd", seg_bcd, prev_bcd);
  endtask
  initial begin
    #1;
    chk("por_hex", seg_hex, pol);
    chk("por_bcd", seg_bcd, pol);
    in = 4'h5; lamp_test = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", seg_hex, pol);
    @(negedge clk);
    rst_n = 1'b1; in = 4'h8; lamp_test = 1'b0;
    #1;
    chk("rel_nochg", seg_hex, pol);
    @(posedge clk);
    #1;
    chk("first_edge", seg_hex, 8'h7F ^ pol);
    prev_hex = model(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    prev_bcd = model(1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hex", seg_hex, pol);
    chk("async_rst_bcd", seg_bcd, pol);
    @(negedge clk);
    in = 4'h3; dp = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_clk_hold", seg_hex, pol);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_nochg2", seg_hex, pol);
    @(posedge clk);
    #1;
    chk("post_rst", seg_hex, 8'hCF ^ pol);
    prev_hex = model(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    prev_bcd = model(1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(4'(2 * k), 1'b0, 1'b0, 1'b0);
      chk("even_sweep", seg_hex, even_exp[k] ^ pol);
    end
    for (int k = 0; k < 16; k++) begin
      step(4'(k), 1'b0, 1'b0, 1'b0);
      chk("bcd_sweep", seg_bcd, (k < 10 ? {1'b0, tbl[k]} : 8'h00) ^ pol);
    end
    step(4'h5, 1'b1, 1'b0, 1'b0);
    chk("dp_on", seg_hex, 8'hED ^ pol);
    step(4'h5, 1'b0, 1'b0, 1'b0);
    chk("dp_off", seg_hex, 8'h6D ^ pol);
    step(4'h3, 1'b1, 1'b1, 1'b1);
    chk("prio_lamp", seg_hex, 8'hFF ^ pol);
    step(4'h3, 1'b1, 1'b1, 1'b0);
    chk("prio_blank", seg_hex, 8'h00 ^ pol);
    step(4'h3, 1'b1, 1'b0, 1'b0);
    chk("prio_decode", seg_hex, 8'hCF ^ pol);
    step(4'h1, 1'b0, 1'b0, 1'b0);
    chk("one", seg_hex, 8'h06 ^ pol);
    step(4'h1, 1'b0, 1'b0, 1'b1);
    chk("one_lamp", seg_hex, 8'hFF ^ pol);
    repeat (300)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
